shift_add_multiplier: RTL and testbench

Sequential unsigned multiplier using the shift-and-add method. It is the multiply counterpart of the team's restoring divider and uses the same start/done handshake style. A single Moore FSM drives an internal datapath: multiplicand register M, accumulator A (N+1 bits including carry), multiplier/low-product register Q, and an iteration counter. The block sits beside the divider in the arithmetic unit and is started by the same sequencer.

---
 rtl/shift_add_multiplier.sv | 115 +++++++++++
 tb/tb_shift_add_multiplier.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned N x N -> 2N multiplier using shift-and-add.
// One Moore FSM (IDLE, LOAD, ADD, SHIFT, DONE) sequences a datapath made of
// multiplicand M, accumulator A (N+1 bits, top bit holds the add carry),
// multiplier/low-product Q and an iteration counter. The product is {A[N-1:0], Q}.
module shift_add_multiplier #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ADD,
      SHIFT,
      DONE
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [N-1:0]    m_reg;
   logic [N:0]      acc;
   logic [N-1:0]    q_reg;
   logic [CW-1:0]   count;

   // State register; reset abandons any operation in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and Moore output decode; start is only looked at in IDLE.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            busy       = 1'b1;
            state_next = ADD;
         end
         ADD: begin
            busy       = 1'b1;
            state_next = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (count == LAST_COUNT) begin
               state_next = DONE;
            end else begin
               state_next = ADD;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: operands are captured only in LOAD, so the product holds through IDLE/DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_reg <= '0;
         acc   <= '0;
         q_reg <= '0;
         count <= '0;
      end else begin
         case (state)
            LOAD: begin
               m_reg <= a;
               q_reg <= b;
               acc   <= '0;
               count <= '0;
            end
            ADD: begin
               if (q_reg[0]) begin
                  acc <= {1'b0, acc[N-1:0]} + {1'b0, m_reg};
               end
            end
            SHIFT: begin
               acc   <= {1'b0, acc[N:1]};
               q_reg <= {acc[0], q_reg[N-1:1]};
               count <= count + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign product = {acc[N-1:0], q_reg};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: self-checking bench for shift_add_multiplier (N=8).
// Expected products come from plain integer multiplication; expected timing
// comes from the documented latency and restart period.
module tb_shift_add_multiplier;

   localparam int N = 8;

   logic           clk;
   logic           rst;
   logic           start;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int errors = 0;
   int checks = 0;

   shift_add_multiplier #(.N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Runs one operation from IDLE and checks result, latency, busy length and done count.
   // With disturb set, start is pulsed and a/b are changed mid-operation.
   task automatic applyStimulus(input logic [N-1:0] opA, input logic [N-1:0] opB,
                                input bit disturb, input string tag);
      logic [2*N-1:0] expected;
      logic [2*N-1:0] doneProduct;
      int busyCycles;
      int doneCount;
      int doneAt;
      expected    = (2*N)'(longint'(opA) * longint'(opB));
      doneProduct = '0;
      doneCount   = 0;
      doneAt      = -1;
      a     = opA;
      b     = opB;
      start = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      busyCycles = busy ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (busy) busyCycles++;
         if (done) begin
            doneCount++;
            if (doneAt < 0) begin
               doneAt      = k;
               doneProduct = product;
            end
         end
         if (disturb && k == 5) begin
            start = 1'b1;
            a     = ~opA;
            b     = opB + 1'b1;
         end
         if (disturb && k == 6) begin
            start = 1'b0;
            a     = opB;
         end
      end
      checkOutput({tag, ".latency"}, doneAt, 2*N+1);
      checkOutput({tag, ".busy_cycles"}, busyCycles, 2*N+1);
      checkOutput({tag, ".done_count"}, doneCount, 1);
      checkOutput({tag, ".product"}, doneProduct, expected);
      checkOutput({tag, ".product_hold"}, product, expected);
   endtask

   // Main sequence: reset, directed cases, random cases, abort, continuous start.
   initial begin
      int nDone;
      int lastDone;
      int consecutive;
      int busySeen;
      bit prevDone;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset.busy", busy, 0);
      checkOutput("reset.done", done, 0);
      checkOutput("reset.product", product, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      applyStimulus(8'd13,  8'd11,  1'b0, "mul_13x11");
      applyStimulus(8'd255, 8'd255, 1'b0, "mul_255x255");
      applyStimulus(8'd0,   8'd200, 1'b0, "mul_0x200");
      applyStimulus(8'd1,   8'd200, 1'b0, "mul_1x200");
      applyStimulus(8'd200, 8'd1,   1'b0, "mul_200x1");
      applyStimulus(8'd77,  8'd0,   1'b0, "mul_77x0");
      applyStimulus(8'd170, 8'd85,  1'b1, "ignore_start");

      for (int i = 0; i < 8; i++) begin
         applyStimulus(N'($urandom), N'($urandom), 1'b0, "random");
      end

      // Abort during the SHIFT of the fourth iteration.
      a     = 8'd255;
      b     = 8'd255;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
      end
      checkOutput("abort.busy_before", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("abort.busy", busy, 0);
      checkOutput("abort.done", done, 0);
      checkOutput("abort.product", product, 0);
      nDone    = 0;
      busySeen = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (done) nDone++;
         if (busy) busySeen++;
      end
      checkOutput("abort.no_done", nDone, 0);
      checkOutput("abort.stays_idle", busySeen, 0);
      applyStimulus(8'd7, 8'd9, 1'b0, "after_abort");

      // start held high: restart every 2N+3 cycles.
      a           = 8'd3;
      b           = 8'd5;
      start       = 1'b1;
      nDone       = 0;
      lastDone    = -1;
      consecutive = 0;
      prevDone    = 1'b0;
      for (int k = 0; k < 120; k++) begin
         @(posedge clk); #1;
         if (done) begin
            nDone++;
            checkOutput("continuous.product", product, 15);
            if (lastDone >= 0) checkOutput("continuous.period", k - lastDone, 2*N+3);
            lastDone = k;
         end
         if (done && prevDone) consecutive++;
         prevDone = done;
      end
      start = 1'b0;
      checkOutput("continuous.done_count", nDone, 6);
      checkOutput("continuous.no_back_to_back_done", consecutive, 0);
      repeat (25) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
